axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master_pkg.sv | 47 ++++
 rtl/axi_lite_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_master_pkg
// Shared bus widths, AXI encodings, reset polarity and FSM state type for the
// single-outstanding AXI-Lite style master.
// Contents:
//   AXI_*_W         bus widths used on every channel
//   AXI_LEN_SINGLE  single-beat burst length
//   AXI_SIZE_8B     8-byte beat size
//   AXI_BURST_INCR  INCR burst encoding
//   AXI_RESP_OKAY   OKAY response encoding
//   RST_ENABLE      level of rst that resets the design
//   state_t         master FSM states
//   respIsError     helper that flags any non-OKAY response
// ---------------------------------------------------------------------------
package axi_lite_master_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = 8;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEF  = 4'd0;
    localparam logic [2:0] AXI_PROT_DEF   = 3'd0;
    localparam logic [3:0] AXI_QOS_DEF    = 4'd0;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is reported to the
    // core as an error, since this master never issues exclusive accesses.
    function automatic logic respIsError(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
// Turns one core request at a time into a single-beat AXI read or write and
// returns a one-cycle completion pulse carrying read data and an error flag.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   req_valid / req_ready      core request handshake (ready only when idle)
//   req_write, req_addr,
//   req_wdata, req_wstrb       request payload, latched on acceptance
//   rsp_valid, rsp_rdata,
//   rsp_err                    one-cycle completion pulse
//   axi_aw_* / axi_w_* / axi_b_*   AXI write address, data, response
//   axi_ar_* / axi_r_*             AXI read address and data
// Parameter:
//   AXI_ID                     ID driven on AR/AW and expected back on R/B
// ---------------------------------------------------------------------------
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] AXI_ID = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AXI_ADDR_W-1:0] req_addr,
    input  logic [AXI_DATA_W-1:0] req_wdata,
    input  logic [AXI_STRB_W-1:0] req_wstrb,

    output logic                  rsp_valid,
    output logic [AXI_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [AXI_ID_W-1:0]   axi_aw_id,
    output logic [AXI_ADDR_W-1:0] axi_aw_addr,
    output logic [7:0]            axi_aw_len,
    output logic [2:0]            axi_aw_size,
    output logic [1:0]            axi_aw_burst,
    output logic [3:0]            axi_aw_cache,
    output logic [2:0]            axi_aw_prot,
    output logic [3:0]            axi_aw_qos,
    output logic                  axi_aw_valid,
    input  logic                  axi_aw_ready,

    output logic [AXI_DATA_W-1:0] axi_w_data,
    output logic [AXI_STRB_W-1:0] axi_w_strb,
    output logic                  axi_w_last,
    output logic                  axi_w_valid,
    input  logic                  axi_w_ready,

    input  logic [AXI_ID_W-1:0]   axi_b_id,
    input  logic [1:0]            axi_b_resp,
    input  logic                  axi_b_valid,
    output logic                  axi_b_ready,

    output logic [AXI_ID_W-1:0]   axi_ar_id,
    output logic [AXI_ADDR_W-1:0] axi_ar_addr,
    output logic [7:0]            axi_ar_len,
    output logic [2:0]            axi_ar_size,
    output logic [1:0]            axi_ar_burst,
    output logic [3:0]            axi_ar_cache,
    output logic [2:0]            axi_ar_prot,
    output logic [3:0]            axi_ar_qos,
    output logic                  axi_ar_valid,
    input  logic                  axi_ar_ready,

    input  logic [AXI_ID_W-1:0]   axi_r_id,
    input  logic [AXI_DATA_W-1:0] axi_r_data,
    input  logic [1:0]            axi_r_resp,
    input  logic                  axi_r_last,
    input  logic                  axi_r_valid,
    output logic                  axi_r_ready
);

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_write;
    logic [AXI_ADDR_W-1:0]   r_addr;
    logic [AXI_DATA_W-1:0]   r_wdata;
    logic [AXI_STRB_W-1:0]   r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [AXI_DATA_W-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_read_err;
    logic                    w_write_err;

    // AW and W handshakes are derived from state and done flags rather than
    // from the valid outputs, so they never loop back through always_comb.
    assign w_aw_fire = (r_state == ST_WREQ) && !r_aw_done && axi_aw_ready;
    assign w_w_fire  = (r_state == ST_WREQ) && !r_w_done  && axi_w_ready;

    // A single-beat read must come back with LAST set and our own ID.
    assign w_read_err  = respIsError(axi_r_resp) || !axi_r_last || (axi_r_id != AXI_ID);
    assign w_write_err = respIsError(axi_b_resp) || (axi_b_id != AXI_ID);

    // State register plus the transaction registers it governs. Reset drops
    // any in-flight transaction on the floor: the next state is IDLE, so no
    // completion pulse is ever produced for it.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state   <= ST_IDLE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write   <= req_write;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_wstrb;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_rdata   <= '0;
                        r_err     <= 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (axi_r_valid) begin
                        r_rdata <= axi_r_data;
                        r_err   <= w_read_err;
                    end
                end
                ST_WREQ: begin
                    if (w_aw_fire) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_w_done <= 1'b1;
                    end
                end
                ST_WRESP: begin
                    if (axi_b_valid) begin
                        r_err <= w_write_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and handshake outputs. In WREQ the AW and W channels run
    // independently; the FSM leaves only when each has completed, either in
    // an earlier cycle (done flag) or in this one (fire).
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        axi_ar_valid = 1'b0;
        axi_r_ready  = 1'b0;
        axi_aw_valid = 1'b0;
        axi_w_valid  = 1'b0;
        axi_b_ready  = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = req_write ? ST_WREQ : ST_RADDR;
                end
            end
            ST_RADDR: begin
                axi_ar_valid = 1'b1;
                if (axi_ar_ready) begin
                    w_next_state = ST_RDATA;
                end
            end
            ST_RDATA: begin
                axi_r_ready = 1'b1;
                if (axi_r_valid) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_WREQ: begin
                axi_aw_valid = !r_aw_done;
                axi_w_valid  = !r_w_done;
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_next_state = ST_WRESP;
                end
            end
            ST_WRESP: begin
                axi_b_ready = 1'b1;
                if (axi_b_valid) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Payloads are forced to zero whenever their valid is low so the bus
    // never shows stale addresses or data.
    assign axi_ar_id    = axi_ar_valid ? AXI_ID         : '0;
    assign axi_ar_addr  = axi_ar_valid ? r_addr         : '0;
    assign axi_ar_len   = axi_ar_valid ? AXI_LEN_SINGLE : '0;
    assign axi_ar_size  = axi_ar_valid ? AXI_SIZE_8B    : '0;
    assign axi_ar_burst = axi_ar_valid ? AXI_BURST_INCR : '0;
    assign axi_ar_cache = axi_ar_valid ? AXI_CACHE_DEF  : '0;
    assign axi_ar_prot  = axi_ar_valid ? AXI_PROT_DEF   : '0;
    assign axi_ar_qos   = axi_ar_valid ? AXI_QOS_DEF    : '0;

    assign axi_aw_id    = axi_aw_valid ? AXI_ID         : '0;
    assign axi_aw_addr  = axi_aw_valid ? r_addr         : '0;
    assign axi_aw_len   = axi_aw_valid ? AXI_LEN_SINGLE : '0;
    assign axi_aw_size  = axi_aw_valid ? AXI_SIZE_8B    : '0;
    assign axi_aw_burst = axi_aw_valid ? AXI_BURST_INCR : '0;
    assign axi_aw_cache = axi_aw_valid ? AXI_CACHE_DEF  : '0;
    assign axi_aw_prot  = axi_aw_valid ? AXI_PROT_DEF   : '0;
    assign axi_aw_qos   = axi_aw_valid ? AXI_QOS_DEF    : '0;

    assign axi_w_data   = axi_w_valid ? r_wdata : '0;
    assign axi_w_strb   = axi_w_valid ? r_wstrb : '0;
    assign axi_w_last   = axi_w_valid;

    // Writes complete with zero data; the pulse fields are quiet otherwise.
    assign rsp_rdata = (rsp_valid && !r_write) ? r_rdata : '0;
    assign rsp_err   = rsp_valid ? r_err : 1'b0;

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master
// Self-checking bench for axi_lite_master. A transaction-level model tracks
// which handshakes of the current request have happened and derives every
// cycle's expected outputs from that; a negedge process compares the DUT to
// it. Directed sequences pin the model with literal expectations, then a
// randomized phase drives random requests, slave readiness, responses and
// occasional resets.
// ---------------------------------------------------------------------------
module tb_axi_lite_master;

    localparam logic [3:0] TB_ID = 4'h3;
    localparam logic [27:0] FIXED_ATTR = {TB_ID, 8'd0, 3'b011, 2'b01, 4'd0, 3'd0, 4'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic [3:0]  axi_aw_id, axi_aw_cache, axi_aw_qos;
    logic [63:0] axi_aw_addr;
    logic [7:0]  axi_aw_len;
    logic [2:0]  axi_aw_size, axi_aw_prot;
    logic [1:0]  axi_aw_burst;
    logic        axi_aw_valid, axi_aw_ready;
    logic [63:0] axi_w_data;
    logic [7:0]  axi_w_strb;
    logic        axi_w_last, axi_w_valid, axi_w_ready;
    logic [3:0]  axi_b_id;
    logic [1:0]  axi_b_resp;
    logic        axi_b_valid, axi_b_ready;
    logic [3:0]  axi_ar_id, axi_ar_cache, axi_ar_qos;
    logic [63:0] axi_ar_addr;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size, axi_ar_prot;
    logic [1:0]  axi_ar_burst;
    logic        axi_ar_valid, axi_ar_ready;
    logic [3:0]  axi_r_id;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic        axi_r_last, axi_r_valid, axi_r_ready;

    int nChecks = 0;
    int nPass   = 0;
    int awCount = 0;
    int wCount  = 0;

    // Transaction-level model of the one outstanding request.
    bit          checkEn = 1'b0;
    bit          mBusy, mWrite, mAddrDone, mWDone, mRespDone, mErr;
    logic [63:0] mAddr, mWdata, mRdata;
    logic [7:0]  mWstrb;

    axi_lite_master #(.AXI_ID(TB_ID)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
        .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_cache(axi_aw_cache),
        .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos), .axi_aw_valid(axi_aw_valid),
        .axi_aw_ready(axi_aw_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
        .axi_b_ready(axi_b_ready),
        .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_cache(axi_ar_cache),
        .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos), .axi_ar_valid(axi_ar_valid),
        .axi_ar_ready(axi_ar_ready),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            nPass++;
        end
    endtask

    // Counts address/data beats actually accepted on the bus.
    always @(posedge clk) begin
        if (axi_aw_valid === 1'b1 && axi_aw_ready === 1'b1) awCount++;
        if (axi_w_valid === 1'b1 && axi_w_ready === 1'b1) wCount++;
    end

    // Model update: at each edge, record which handshakes the model says
    // were offered and the bench's slave accepted. A response cycle ends the
    // transaction; reset drops it.
    always @(posedge clk) begin
        bit eAr, eR, eAw, eW, eB;
        eAr = mBusy && !mWrite && !mAddrDone;
        eR  = mBusy && !mWrite && mAddrDone && !mRespDone;
        eAw = mBusy && mWrite && !mAddrDone;
        eW  = mBusy && mWrite && !mWDone;
        eB  = mBusy && mWrite && mAddrDone && mWDone && !mRespDone;
        if (rst) begin
            checkEn = 1'b1;
            mBusy = 0; mWrite = 0; mAddrDone = 0; mWDone = 0; mRespDone = 0; mErr = 0;
            mRdata = '0;
        end else if (!mBusy) begin
            if (req_valid) begin
                mBusy = 1; mWrite = req_write; mAddr = req_addr;
                mWdata = req_wdata; mWstrb = req_wstrb;
                mAddrDone = 0; mWDone = 0; mRespDone = 0; mErr = 0; mRdata = '0;
            end
        end else if (mRespDone) begin
            mBusy = 0;
        end else begin
            if ((eAr && axi_ar_ready) || (eAw && axi_aw_ready)) mAddrDone = 1;
            if (eW && axi_w_ready) mWDone = 1;
            if (eR && axi_r_valid) begin
                mRespDone = 1;
                mRdata = axi_r_data;
                mErr = (axi_r_resp != 2'b00) || !axi_r_last || (axi_r_id != TB_ID);
            end
            if (eB && axi_b_valid) begin
                mRespDone = 1;
                mErr = (axi_b_resp != 2'b00) || (axi_b_id != TB_ID);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit eAr, eR, eAw, eW, eB, eRsp;
        if (checkEn) begin
            eAr  = mBusy && !mWrite && !mAddrDone;
            eR   = mBusy && !mWrite && mAddrDone && !mRespDone;
            eAw  = mBusy && mWrite && !mAddrDone;
            eW   = mBusy && mWrite && !mWDone;
            eB   = mBusy && mWrite && mAddrDone && mWDone && !mRespDone;
            eRsp = mBusy && mRespDone;
            checkOutput("req_ready", req_ready, !mBusy);
            checkOutput("ar_valid", axi_ar_valid, eAr);
            checkOutput("r_ready", axi_r_ready, eR);
            checkOutput("aw_valid", axi_aw_valid, eAw);
            checkOutput("w_valid", axi_w_valid, eW);
            checkOutput("b_ready", axi_b_ready, eB);
            checkOutput("rsp_valid", rsp_valid, eRsp);
            checkOutput("ar_addr", axi_ar_addr, eAr ? mAddr : 64'd0);
            checkOutput("ar_attr", {axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
                                    axi_ar_cache, axi_ar_prot, axi_ar_qos}, eAr ? FIXED_ATTR : 28'd0);
            checkOutput("aw_addr", axi_aw_addr, eAw ? mAddr : 64'd0);
            checkOutput("aw_attr", {axi_aw_id, axi_aw_len, axi_aw_size, axi_aw_burst,
                                    axi_aw_cache, axi_aw_prot, axi_aw_qos}, eAw ? FIXED_ATTR : 28'd0);
            checkOutput("w_data", axi_w_data, eW ? mWdata : 64'd0);
            checkOutput("w_strb_last", {axi_w_strb, axi_w_last}, eW ? {mWstrb, 1'b1} : 9'd0);
            if (eRsp) begin
                checkOutput("rsp_rdata", rsp_rdata, mWrite ? 64'd0 : mRdata);
                checkOutput("rsp_err", rsp_err, mErr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit isWrite, input logic [63:0] addr,
                                 input logic [63:0] data, input logic [7:0] strb);
        req_valid = 1'b1;
        req_write = isWrite;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
    endtask

    task automatic quietSlave();
        axi_aw_ready = 0; axi_w_ready = 0; axi_ar_ready = 0;
        axi_r_valid = 0; axi_r_data = '0; axi_r_resp = 0; axi_r_last = 0; axi_r_id = 0;
        axi_b_valid = 0; axi_b_resp = 0; axi_b_id = 0;
    endtask

    // Ticks until the completion pulse shows, bounded.
    task automatic waitRsp(output int cycles);
        cycles = 0;
        while (rsp_valid !== 1'b1 && cycles < 50) begin
            tick();
            cycles++;
        end
        if (cycles >= 50) checkOutput("rsp timeout", 64'd0, 64'd1);
    endtask

    // One transaction against an always-ready slave answering with the given
    // response fields, then literal checks on the completion pulse.
    task automatic runTxn(input bit isWrite, input logic [63:0] addr, input logic [63:0] data,
                          input logic [1:0] resp, input bit last, input logic [3:0] id,
                          input bit expErr, input logic [63:0] expData);
        int lat;
        applyStimulus(isWrite, addr, data, 8'hFF);
        axi_ar_ready = 1; axi_aw_ready = 1; axi_w_ready = 1;
        axi_r_valid = 1; axi_r_data = data; axi_r_resp = resp; axi_r_last = last; axi_r_id = id;
        axi_b_valid = 1; axi_b_resp = resp; axi_b_id = id;
        tick();
        req_valid = 0;
        waitRsp(lat);
        checkOutput("txn err", rsp_err, expErr);
        checkOutput("txn rdata", rsp_rdata, expData);
        tick();
        quietSlave();
    endtask

    initial begin
        int lat;
        int awBase, wBase;
        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        quietSlave();
        repeat (3) tick();
        rst = 0;
        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset valids", {axi_ar_valid, axi_aw_valid, axi_w_valid,
                                     axi_r_ready, axi_b_ready, rsp_valid}, 6'd0);
        tick();

        // Basic read with immediate slaves: three cycles from acceptance.
        applyStimulus(0, 64'h0200_BFF8, 64'd0, 8'd0);
        axi_ar_ready = 1; axi_r_valid = 1; axi_r_data = 64'h1234; axi_r_last = 1; axi_r_id = TB_ID;
        tick();
        req_valid = 0;
        checkOutput("rd ar_valid", axi_ar_valid, 1);
        checkOutput("rd ar_addr", axi_ar_addr, 64'h0200_BFF8);
        waitRsp(lat);
        checkOutput("rd latency", 64'(lat + 1), 64'd3);
        checkOutput("rd rdata", rsp_rdata, 64'h1234);
        checkOutput("rd err", rsp_err, 0);
        tick();
        checkOutput("rd pulse one cycle", rsp_valid, 0);
        checkOutput("rd back idle", req_ready, 1);
        quietSlave();

        // Write with W accepted at once and AW held for three cycles.
        applyStimulus(1, 64'h0200_4000, 64'hFF, 8'hFF);
        axi_w_ready = 1; axi_b_valid = 1; axi_b_id = TB_ID;
        tick();
        req_valid = 0;
        checkOutput("wr both valid", {axi_aw_valid, axi_w_valid}, 2'b11);
        checkOutput("wr w_data", axi_w_data, 64'hFF);
        tick();
        checkOutput("wr w dropped", {axi_aw_valid, axi_w_valid, axi_b_ready}, 3'b100);
        tick();
        checkOutput("wr aw held", axi_aw_valid, 1);
        axi_aw_ready = 1;
        tick();
        axi_aw_ready = 0;
        checkOutput("wr b_ready after both", {axi_aw_valid, axi_b_ready}, 2'b01);
        waitRsp(lat);
        checkOutput("wr err", rsp_err, 0);
        checkOutput("wr rdata zero", rsp_rdata, 64'd0);
        tick();
        quietSlave();

        // Write with W accepted two cycles after AW: one beat each.
        awBase = awCount; wBase = wCount;
        applyStimulus(1, 64'h0000_1000, 64'hDEAD_BEEF, 8'h0F);
        axi_aw_ready = 1; axi_b_valid = 1; axi_b_id = TB_ID;
        tick();
        req_valid = 0;
        tick();
        checkOutput("aw-first state", {axi_aw_valid, axi_w_valid}, 2'b01);
        tick();
        axi_w_ready = 1;
        tick();
        axi_w_ready = 0;
        waitRsp(lat);
        checkOutput("single AW beat", 64'(awCount - awBase), 64'd1);
        checkOutput("single W beat", 64'(wCount - wBase), 64'd1);
        tick();
        quietSlave();

        // Error responses.
        runTxn(0, 64'h40, 64'h55AA, 2'b10, 1, TB_ID, 1, 64'h55AA);
        runTxn(1, 64'h48, 64'h1, 2'b11, 1, TB_ID, 1, 64'd0);
        runTxn(0, 64'h50, 64'h77, 2'b00, 0, TB_ID, 1, 64'h77);
        runTxn(1, 64'h58, 64'h2, 2'b00, 1, 4'h9, 1, 64'd0);
        runTxn(0, 64'h60, 64'h99, 2'b00, 1, TB_ID, 0, 64'h99);

        // Reset while waiting for read data.
        applyStimulus(0, 64'h80, 64'd0, 8'd0);
        axi_ar_ready = 1;
        tick();
        req_valid = 0;
        tick();
        checkOutput("rdata wait r_ready", axi_r_ready, 1);
        rst = 1;
        tick();
        rst = 0;
        axi_r_valid = 1; axi_r_last = 1; axi_r_id = TB_ID;
        checkOutput("mid reset req_ready", req_ready, 1);
        checkOutput("mid reset valids", {axi_ar_valid, axi_aw_valid, axi_w_valid,
                                         axi_r_ready, axi_b_ready, rsp_valid}, 6'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("no rsp after reset", rsp_valid, 0);
        end
        quietSlave();

        // Back-to-back read then write with req_valid held throughout.
        applyStimulus(0, 64'hA0, 64'd0, 8'd0);
        axi_ar_ready = 1; axi_aw_ready = 1; axi_w_ready = 1;
        axi_r_valid = 1; axi_r_data = 64'h4242; axi_r_last = 1; axi_r_id = TB_ID;
        axi_b_valid = 1; axi_b_id = TB_ID;
        tick();
        applyStimulus(1, 64'hB0, 64'h3, 8'h01);
        waitRsp(lat);
        checkOutput("b2b busy during rsp", req_ready, 0);
        tick();
        checkOutput("b2b accept after rsp", {req_ready, axi_aw_valid}, 2'b10);
        tick();
        req_valid = 0;
        checkOutput("b2b write issued", axi_aw_addr, 64'hB0);
        waitRsp(lat);
        checkOutput("b2b write err", rsp_err, 0);
        tick();
        quietSlave();

        // Randomized traffic, including noise on R/B and rare resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(399) == 0);
            req_valid = $urandom_range(1);
            req_write = $urandom_range(1);
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            req_wstrb = 8'($urandom);
            axi_ar_ready = ($urandom_range(2) != 0);
            axi_aw_ready = ($urandom_range(2) != 0);
            axi_w_ready  = ($urandom_range(2) != 0);
            axi_r_valid  = $urandom_range(1);
            axi_r_data   = {$urandom, $urandom};
            axi_r_resp   = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            axi_r_last   = ($urandom_range(7) != 0);
            axi_r_id     = ($urandom_range(7) == 0) ? 4'($urandom) : TB_ID;
            axi_b_valid  = $urandom_range(1);
            axi_b_resp   = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            axi_b_id     = ($urandom_range(7) == 0) ? 4'($urandom) : TB_ID;
            tick();
        end
        rst = 0; req_valid = 0;
        quietSlave();
        repeat (2) tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
